// File: rtl/cmos_ioctl_xfer.sv
// -----------------------------------------------------------------------------
// cmos_ioctl_xfer
// Moves a nibble-wide CMOS/NVRAM between the game core and the HPS ioctl
// interface. An upload (core->HPS) reads CMOS nibbles and returns them as bytes
// with the high nibble forced to F. A download (HPS->core) writes the low
// nibble of each byte into CMOS. The bridge takes the CMOS port only while a
// session with a matching file index is active. It also flags CPU writes made
// outside a session, so the host knows the NVRAM needs saving.
//
// Ports
//   clk_sys        : sole clock, rising edge
//   reset          : asynchronous, active-high
//   ioctl_upload   : upload session active
//   ioctl_download : download session active
//   ioctl_index    : file index of the current session
//   ioctl_addr     : byte address of the current transfer
//   ioctl_rd       : one-cycle upload read strobe
//   ioctl_wr       : one-cycle download write strobe
//   ioctl_dout     : download data byte
//   ioctl_din      : upload data byte returned to HPS
//   ioctl_wait     : stall request to HPS while a CMOS read is in flight
//   cmos_cpu_we    : game CPU CMOS write strobe (dirty tracking)
//   cmos_sel       : bridge owns the CMOS port
//   cmos_addr      : CMOS address
//   cmos_rd_data   : CMOS read nibble, valid RD_LAT cycles after cmos_addr
//   cmos_wr_data   : CMOS write nibble
//   cmos_we        : one-cycle CMOS write enable
//   dirty          : CMOS modified by the CPU since the last save/load
// -----------------------------------------------------------------------------
module cmos_ioctl_xfer #(
  parameter logic [15:0] INDEX  = 16'd4,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ioctl_upload,
  input  logic                     ioctl_download,
  input  logic [15:0]              ioctl_index,
  input  logic [24:0]              ioctl_addr,
  input  logic                     ioctl_rd,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_dout,
  output logic [7:0]               ioctl_din,
  output logic                     ioctl_wait,
  input  logic                     cmos_cpu_we,
  output logic                     cmos_sel,
  output logic [$clog2(DEPTH)-1:0] cmos_addr,
  input  logic [3:0]               cmos_rd_data,
  output logic [3:0]               cmos_wr_data,
  output logic                     cmos_we,
  output logic                     dirty
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [25:0] W_DEPTH  = 26'(DEPTH);
  localparam logic [1:0]  LAT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_cnt;
  logic [7:0]      r_din;
  logic            r_wait;
  logic            r_sel;
  logic            r_sel_d;
  logic [AW-1:0]   r_addr;
  logic [3:0]      r_wr_data;
  logic            r_we;
  logic            r_dirty;

  logic w_match;
  logic w_in_range;
  logic w_both;
  logic w_sel_next;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_sel_fall;
  logic w_dirty_set;
  logic w_unused_hi;

  assign w_match     = (ioctl_index == INDEX);
  assign w_in_range  = ({1'b0, ioctl_addr} < W_DEPTH);
  assign w_both      = ioctl_upload & ioctl_download;
  assign w_sel_next  = (ioctl_upload ^ ioctl_download) & w_match;
  assign w_rd_ok     = ioctl_rd & r_sel & ~w_both & (r_state == IDLE);
  // A write also requires the port to stay owned after this edge, so a
  // session ending on the strobe cycle cannot leave cmos_we high with
  // cmos_sel already low.
  assign w_wr_ok     = ioctl_wr & r_sel & w_sel_next & w_in_range & (r_state == IDLE);
  assign w_sel_fall  = r_sel_d & ~r_sel;
  assign w_dirty_set = cmos_cpu_we & ~r_sel;
  // The high nibble of download data has no CMOS storage.
  assign w_unused_hi = ^ioctl_dout[7:4];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_din     <= '0;
      r_wait    <= 1'b0;
      r_sel     <= 1'b0;
      r_sel_d   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_we      <= 1'b0;
      r_dirty   <= 1'b0;
    end else begin
      r_sel   <= w_sel_next;
      r_sel_d <= r_sel;
      r_we    <= 1'b0;

      // Set takes priority over the end-of-session clear.
      if (w_dirty_set) begin
        r_dirty <= 1'b1;
      end else if (w_sel_fall) begin
        r_dirty <= 1'b0;
      end

      // Once started, a read always runs to completion even if the session
      // drops, so ioctl_din is updated before ioctl_wait is released.
      case (r_state)
        IDLE: begin
          if (w_rd_ok) begin
            if (w_in_range) begin
              r_addr  <= ioctl_addr[AW-1:0];
              r_wait  <= 1'b1;
              r_state <= RD_REQ;
            end else begin
              r_din <= 8'hFF;
            end
          end else if (w_wr_ok) begin
            r_addr    <= ioctl_addr[AW-1:0];
            r_wr_data <= ioctl_dout[3:0];
            r_we      <= 1'b1;
          end
        end
        RD_REQ: begin
          r_cnt   <= LAT_LOAD;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= RD_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RD_DONE: begin
          r_din   <= {4'hF, cmos_rd_data};
          r_wait  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ioctl_din    = r_din;
  assign ioctl_wait   = r_wait;
  assign cmos_sel     = r_sel;
  assign cmos_addr    = r_addr;
  assign cmos_wr_data = r_wr_data;
  assign cmos_we      = r_we;
  assign dirty        = r_dirty;

endmodule

// File: tb/tb_cmos_ioctl_xfer.sv
module tb_cmos_ioctl_xfer;

  localparam int          DEPTH = 1024;
  localparam logic [15:0] IDX   = 16'd4;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload, ioctl_download;
  logic [15:0] ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd, ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cmos_cpu_we;
  logic        cmos_sel;
  logic [9:0]  cmos_addr;
  logic [3:0]  cmos_rd_data;
  logic [3:0]  cmos_wr_data;
  logic        cmos_we;
  logic        dirty;

  int tests = 0;
  int fails = 0;

  // Reference model: expected nibble content of every CMOS location.
  logic [3:0] ref_mem [DEPTH];

  // CMOS RAM environment, read latency 1.
  logic [3:0] ram [DEPTH];
  logic [3:0] ram_q;
  always_ff @(posedge clk_sys) begin
    if (cmos_we) ram[cmos_addr] <= cmos_wr_data;
    ram_q <= ram[cmos_addr];
  end
  assign cmos_rd_data = ram_q;

  always #5 clk_sys = ~clk_sys;

  cmos_ioctl_xfer #(.INDEX(16'd4), .DEPTH(1024), .RD_LAT(1)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_upload   (ioctl_upload),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_rd       (ioctl_rd),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_din      (ioctl_din),
    .ioctl_wait     (ioctl_wait),
    .cmos_cpu_we    (cmos_cpu_we),
    .cmos_sel       (cmos_sel),
    .cmos_addr      (cmos_addr),
    .cmos_rd_data   (cmos_rd_data),
    .cmos_wr_data   (cmos_wr_data),
    .cmos_we        (cmos_we),
    .dirty          (dirty)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_session(input logic up, input logic dn, input logic [15:0] idx);
    ioctl_upload   = up;
    ioctl_download = dn;
    ioctl_index    = idx;
    tick();
    tick();
  endtask

  // Issue one read strobe and follow ioctl_wait until it drops (bounded).
  task automatic do_read(input logic [24:0] a, output int n, output logic [7:0] d);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      tick();
    end
    d = ioctl_din;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ioctl_upload = 0; ioctl_download = 0; ioctl_index = '0; ioctl_addr = '0;
    ioctl_rd = 0; ioctl_wr = 0; ioctl_dout = '0; cmos_cpu_we = 0;
    tick();
    tick();
    tests++; if (ioctl_din !== 8'h00) begin fails++; $display("FAIL reset_din: got %h want 00", ioctl_din); end
    tests++; if (ioctl_wait !== 1'b0) begin fails++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
    tests++; if (cmos_sel !== 1'b0) begin fails++; $display("FAIL reset_sel: got %b want 0", cmos_sel); end
    tests++; if (cmos_addr !== 10'h000) begin fails++; $display("FAIL reset_addr: got %h want 000", cmos_addr); end
    tests++; if (cmos_wr_data !== 4'h0) begin fails++; $display("FAIL reset_wr_data: got %h want 0", cmos_wr_data); end
    tests++; if (cmos_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", cmos_we); end
    tests++; if (dirty !== 1'b0) begin fails++; $display("FAIL reset_dirty: got %b want 0", dirty); end
    reset = 1'b0;
    tick();
  endtask

  // Load every location with random data through the download path.
  task automatic fill_cmos();
    logic [7:0] v;
    set_session(1'b0, 1'b1, IDX);
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      ioctl_addr = 25'(i);
      ioctl_dout = v;
      ioctl_wr   = 1'b1;
      tick();
      ref_mem[i] = v[3:0];
    end
    ioctl_wr = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [24:0] a;
    logic [7:0]  v;
    int          wait_seen;
    set_session(1'b0, 1'b1, IDX);
    ioctl_addr = 25'h3FF; ioctl_dout = 8'h5C; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tests++; if (cmos_we !== 1'b1) begin fails++; $display("FAIL wr3ff_we: got %b want 1", cmos_we); end
    tests++; if (cmos_addr !== 10'h3FF) begin fails++; $display("FAIL wr3ff_addr: got %h want 3ff", cmos_addr); end
    tests++; if (cmos_wr_data !== 4'hC) begin fails++; $display("FAIL wr3ff_data: got %h want c", cmos_wr_data); end
    ref_mem[10'h3FF] = 4'hC;
    tick();
    tests++; if (cmos_we !== 1'b0) begin fails++; $display("FAIL wr3ff_pulse: got %b want 0", cmos_we); end
    // back-to-back random writes, some out of range
    wait_seen = 0;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) a = 25'(DEPTH + $urandom_range(0, 5000));
      else                           a = 25'($urandom_range(0, DEPTH - 1));
      v = 8'($urandom);
      ioctl_addr = a; ioctl_dout = v; ioctl_wr = 1'b1;
      tick();
      if (ioctl_wait) wait_seen++;
      if (a < DEPTH) begin
        ref_mem[a[9:0]] = v[3:0];
        tests++;
        if (cmos_we !== 1'b1 || cmos_addr !== a[9:0] || cmos_wr_data !== v[3:0]) begin
          fails++;
          $display("FAIL wr_rand: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                   cmos_we, cmos_addr, cmos_wr_data, a[9:0], v[3:0]);
        end
      end else begin
        tests++; if (cmos_we !== 1'b0) begin fails++; $display("FAIL wr_oob: got we=%b want 0 (addr %h)", cmos_we, a); end
      end
    end
    ioctl_wr = 1'b0;
    tick();
    tests++; if (cmos_we !== 1'b0) begin fails++; $display("FAIL wr_end: got we=%b want 0", cmos_we); end
    tests++; if (wait_seen != 0) begin fails++; $display("FAIL wr_wait: got %0d wait cycles want 0", wait_seen); end
  endtask

  task automatic test_read_basic();
    int         n;
    logic [7:0] d;
    set_session(1'b0, 1'b1, IDX);
    ioctl_addr = 25'h005; ioctl_dout = 8'h3A; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    ref_mem[5] = 4'hA;
    set_session(1'b1, 1'b0, IDX);
    do_read(25'h005, n, d);
    tests++; if (n != 3) begin fails++; $display("FAIL rd5_wait_cycles: got %0d want 3", n); end
    tests++; if (d !== 8'hFA) begin fails++; $display("FAIL rd5_din: got %h want fa", d); end
  endtask

  task automatic test_random_reads();
    int          n;
    logic [7:0]  d;
    logic [24:0] a;
    set_session(1'b1, 1'b0, IDX);
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      a = 25'd0;
      else if (i == 1) a = 25'(DEPTH - 1);
      else             a = 25'($urandom_range(0, DEPTH - 1));
      do_read(a, n, d);
      tests++;
      if (n != 3 || d !== {4'hF, ref_mem[a[9:0]]}) begin
        fails++;
        $display("FAIL rd_rand: addr %h got wait=%0d din=%h want wait=3 din=%h", a, n, d, {4'hF, ref_mem[a[9:0]]});
      end
    end
  endtask

  task automatic test_rd_during_read();
    int          n;
    logic [24:0] a, b;
    int          extra;
    set_session(1'b1, 1'b0, IDX);
    a = 25'($urandom_range(0, DEPTH - 1));
    b = a;
    for (int k = 0; k < 64 && ref_mem[b[9:0]] == ref_mem[a[9:0]]; k++) b = 25'($urandom_range(0, DEPTH - 1));
    ioctl_addr = a; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      if (n == 1) begin ioctl_addr = b; ioctl_rd = 1'b1; end
      else ioctl_rd = 1'b0;
      tick();
    end
    ioctl_rd = 1'b0;
    tests++; if (n != 3) begin fails++; $display("FAIL rd_viol_cycles: got %0d want 3", n); end
    tests++; if (ioctl_din !== {4'hF, ref_mem[a[9:0]]}) begin fails++; $display("FAIL rd_viol_din: got %h want %h", ioctl_din, {4'hF, ref_mem[a[9:0]]}); end
    extra = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (ioctl_wait) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL rd_viol_restart: got %0d wait cycles want 0", extra); end
  endtask

  task automatic test_oob_read();
    logic [24:0] oob [3];
    int          seen;
    set_session(1'b1, 1'b0, IDX);
    oob[0] = 25'(DEPTH);
    oob[1] = 25'h1FFFFFF;
    oob[2] = 25'(DEPTH + $urandom_range(1, 1000000));
    for (int i = 0; i < 3; i++) begin
      // put a known non-FF value on ioctl_din first
      do_read(25'h005, seen, ioctl_dout);
      ioctl_addr = oob[i]; ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      tests++; if (ioctl_din !== 8'hFF) begin fails++; $display("FAIL rd_oob_din: addr %h got %h want ff", oob[i], ioctl_din); end
      seen = ioctl_wait ? 1 : 0;
      for (int k = 0; k < 3; k++) begin tick(); if (ioctl_wait) seen++; end
      tests++; if (seen != 0) begin fails++; $display("FAIL rd_oob_wait: got %0d wait cycles want 0", seen); end
    end
  endtask

  task automatic test_session_end_mid_read();
    int          n;
    logic [24:0] a;
    set_session(1'b1, 1'b0, IDX);
    a = 25'($urandom_range(0, DEPTH - 1));
    ioctl_addr = a; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin n++; tick(); end
    tests++; if (n != 3) begin fails++; $display("FAIL end_mid_cycles: got %0d want 3", n); end
    tests++; if (ioctl_din !== {4'hF, ref_mem[a[9:0]]}) begin fails++; $display("FAIL end_mid_din: got %h want %h", ioctl_din, {4'hF, ref_mem[a[9:0]]}); end
    tests++; if (cmos_sel !== 1'b0) begin fails++; $display("FAIL end_mid_sel: got %b want 0", cmos_sel); end
  endtask

  task automatic test_both_high();
    logic [7:0] d0;
    int         we_seen, wait_seen;
    set_session(1'b1, 1'b0, IDX);
    d0 = ioctl_din;
    we_seen = 0; wait_seen = 0;
    // first strobe on the cycle both go high (port still owned), then again later
    for (int rep = 0; rep < 2; rep++) begin
      ioctl_download = 1'b1;
      ioctl_addr = 25'($urandom_range(0, DEPTH - 1));
      ioctl_dout = 8'($urandom);
      ioctl_rd = 1'b1; ioctl_wr = 1'b1;
      tick();
      ioctl_rd = 1'b0; ioctl_wr = 1'b0;
      if (cmos_we) we_seen++;
      if (ioctl_wait) wait_seen++;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (cmos_we) we_seen++;
        if (ioctl_wait) wait_seen++;
      end
    end
    tests++; if (we_seen != 0) begin fails++; $display("FAIL both_we: got %0d pulses want 0", we_seen); end
    tests++; if (wait_seen != 0) begin fails++; $display("FAIL both_wait: got %0d cycles want 0", wait_seen); end
    tests++; if (ioctl_din !== d0) begin fails++; $display("FAIL both_din: got %h want %h", ioctl_din, d0); end
    set_session(1'b0, 1'b0, IDX);
  endtask

  task automatic test_dirty();
    int we_seen;
    set_session(1'b0, 1'b1, 16'd0);
    tests++; if (cmos_sel !== 1'b0) begin fails++; $display("FAIL idx0_sel: got %b want 0", cmos_sel); end
    we_seen = 0;
    ioctl_addr = 25'd3; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (cmos_we) we_seen++;
    tick();
    if (cmos_we) we_seen++;
    tests++; if (we_seen != 0) begin fails++; $display("FAIL idx0_we: got %0d pulses want 0", we_seen); end
    tests++; if (dirty !== 1'b0) begin fails++; $display("FAIL dirty_pre: got %b want 0", dirty); end
    cmos_cpu_we = 1'b1;
    tick();
    cmos_cpu_we = 1'b0;
    tests++; if (dirty !== 1'b1) begin fails++; $display("FAIL dirty_set: got %b want 1", dirty); end
    set_session(1'b1, 1'b0, IDX);
    tests++; if (cmos_sel !== 1'b1) begin fails++; $display("FAIL upl_sel: got %b want 1", cmos_sel); end
    ioctl_upload = 1'b0;
    tick();
    tick();
    tests++; if (dirty !== 1'b0) begin fails++; $display("FAIL dirty_clear: got %b want 0", dirty); end
    // CPU writes while the bridge owns the port do not mark dirty
    set_session(1'b1, 1'b0, IDX);
    cmos_cpu_we = 1'b1;
    tick();
    cmos_cpu_we = 1'b0;
    tests++; if (dirty !== 1'b0) begin fails++; $display("FAIL dirty_locked: got %b want 0", dirty); end
    // set coinciding with the end-of-session clear
    ioctl_upload = 1'b0;
    tick();
    cmos_cpu_we = 1'b1;
    tick();
    cmos_cpu_we = 1'b0;
    tests++; if (dirty !== 1'b1) begin fails++; $display("FAIL dirty_set_wins: got %b want 1", dirty); end
  endtask

  task automatic test_reset_mid_read();
    int          n, hung;
    logic [7:0]  d;
    logic [24:0] a;
    set_session(1'b1, 1'b0, IDX);
    ioctl_addr = 25'($urandom_range(0, DEPTH - 1)); ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    tests++; if (ioctl_wait !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: got wait=%b want 1", ioctl_wait); end
    reset = 1'b1;
    #1;
    tests++; if (ioctl_wait !== 1'b0) begin fails++; $display("FAIL rst_mid_async: got wait=%b want 0", ioctl_wait); end
    tick();
    reset = 1'b0;
    hung = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (ioctl_wait || ioctl_din !== 8'h00) hung++; end
    tests++; if (hung != 0) begin fails++; $display("FAIL rst_mid_abandon: got %0d bad cycles want 0", hung); end
    a = 25'($urandom_range(0, DEPTH - 1));
    do_read(a, n, d);
    tests++;
    if (n != 3 || d !== {4'hF, ref_mem[a[9:0]]}) begin
      fails++;
      $display("FAIL rst_mid_next: got wait=%0d din=%h want wait=3 din=%h", n, d, {4'hF, ref_mem[a[9:0]]});
    end
  endtask

  // cmos_we must never be seen without port ownership.
  always @(negedge clk_sys) begin
    if (!reset && cmos_we) begin
      tests++;
      if (!cmos_sel) begin fails++; $display("FAIL we_without_sel: got sel=0 want 1"); end
    end
  end

  initial begin
    test_reset();
    fill_cmos();
    test_write();
    test_read_basic();
    test_random_reads();
    test_rd_during_read();
    test_oob_read();
    test_session_end_mid_read();
    test_both_high();
    test_dirty();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmos_ioctl_xfer.md
CMOS_IOCTL_XFER -- requirements
Module: cmos_ioctl_xfer

Interface
REQ-001 SHALL have parameter INDEX, default 16'd4: ioctl_index value selecting the CMOS/NVRAM file.
REQ-002 SHALL have parameter DEPTH, default 1024: number of CMOS nibble locations, power of two.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..3: CMOS read latency in clk_sys cycles.
REQ-004 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ioctl_upload  in  1  HPS upload (core->HPS) session active.
REQ-007 ioctl_download  in  1  HPS download (HPS->core) session active.
REQ-008 ioctl_index  in  16  file index of the current session.
REQ-009 ioctl_addr  in  25  byte address of the current transfer.
REQ-010 ioctl_rd  in  1  one-cycle upload read strobe.
REQ-011 ioctl_wr  in  1  one-cycle download write strobe.
REQ-012 ioctl_dout  in  8  download data byte.
REQ-013 ioctl_din  out  8  upload data byte returned to HPS.
REQ-014 ioctl_wait  out  1  stall request to HPS; HPS issues no new strobe while high.
REQ-015 cmos_cpu_we  in  1  game CPU CMOS write strobe, used for dirty tracking.
REQ-016 cmos_sel  out  1  bridge owns the CMOS port; the game CPU is locked out while high.
REQ-017 cmos_addr  out  log2(DEPTH)  CMOS address.
REQ-018 cmos_rd_data  in  4  CMOS read data, valid RD_LAT cycles after cmos_addr.
REQ-019 cmos_wr_data  out  4  CMOS write nibble.
REQ-020 cmos_we  out  1  one-cycle CMOS write enable.
REQ-021 dirty  out  1  CMOS modified by CPU since the last save or load.

Function
REQ-022 match = (ioctl_index == INDEX); in_range = (ioctl_addr < DEPTH).
REQ-023 cmos_sel SHALL be registered high when (ioctl_upload XOR ioctl_download) and match; low otherwise; 1-cycle lag.
REQ-024 When ioctl_upload and ioctl_download are both high, strobes SHALL be ignored: no cmos_we, no wait, ioctl_din unchanged.
REQ-025 FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
REQ-026 IDLE: ioctl_rd and cmos_sel and in_range -> RD_REQ. Same cycle: latch cmos_addr = ioctl_addr[log2(DEPTH)-1:0]; ioctl_wait=1 on the next edge.
REQ-027 RD_REQ -> RD_WAIT. Load a latency counter with RD_LAT-1.
REQ-028 RD_WAIT: decrement the counter; at 0 -> RD_DONE.
REQ-029 RD_DONE: ioctl_din <= {4'hF, cmos_rd_data}; ioctl_wait <= 0; -> IDLE.
REQ-030 Total ioctl_rd-to-ioctl_wait-low latency SHALL be RD_LAT+2 cycles.
REQ-031 ioctl_rd while cmos_sel and not in_range SHALL set ioctl_din=8'hFF next cycle, with no wait and no FSM change.
REQ-032 ioctl_rd in any state other than IDLE (protocol violation) SHALL be ignored.
REQ-033 Download write with ioctl_wr, cmos_sel and in_range SHALL, on the next edge, drive cmos_addr=ioctl_addr, cmos_wr_data=ioctl_dout[3:0] and cmos_we=1 for exactly one cycle.
REQ-034 The high nibble of download data SHALL be discarded.
REQ-035 An out-of-range write SHALL produce no cmos_we.
REQ-036 ioctl_wr during any non-IDLE state SHALL be ignored.
REQ-037 cmos_we SHALL never assert while cmos_sel is low.
REQ-038 dirty SHALL set on cmos_cpu_we while cmos_sel is low.
REQ-039 dirty SHALL clear on the cycle after a falling edge of cmos_sel that ends a matched upload or download.
REQ-040 If set and clear coincide, set SHALL win.
REQ-041 If the session ends (ioctl_upload falls) mid-read, the FSM SHALL finish to IDLE, update ioctl_din, then drop ioctl_wait.

Reset
REQ-042 While reset is high: FSM=IDLE, ioctl_din=0, ioctl_wait=0, cmos_sel=0, cmos_addr=0, cmos_wr_data=0, cmos_we=0, dirty=0, counter=0.
REQ-043 Reset asserted mid-read SHALL drop ioctl_wait immediately (asynchronous) and abandon the read.

Verification
REQ-044 Upload, RD_LAT=1, CMOS[0x005]=4'hA, ioctl_rd at addr 5 -> wait high for 3 cycles, ioctl_din=8'hFA, wait low.
REQ-045 Upload rd at addr 1024 -> ioctl_din=8'hFF next cycle, wait never high.
REQ-046 Download: wr addr 0x3FF, dout 8'h5C -> single cmos_we pulse, addr 0x3FF, data 4'hC.
REQ-047 Download with index 0 -> cmos_sel=0, no cmos_we; a cmos_cpu_we pulse sets dirty=1; a matched upload then cmos_sel falling -> dirty=0.
REQ-048 Reset pulse 1 cycle after ioctl_rd -> wait=0 and FSM IDLE. Next read completes normally.
REQ-049 Upload and download both high, rd and wr strobed -> no cmos_we, no wait, din unchanged.
